// File: rtl/keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl
// Sequencer behind the 4x4 keypad scan driver. It turns the raw per-scan
// stream (code + toggling change flag) into clean one-shot key events. It
// debounces each press, accepts it exactly once, detects release, and
// assembles multi-digit BCD entries.
//
// Ports
//   clk              in   system clock (scan clock domain)
//   rst              in   asynchronous, active-high reset
//   i_cambio_digito  in   toggles on every scan cycle that sees a pressed row
//   i_digito[4:0]    in   scanned code: 0..15 key, 16 no key, 17 invalid
//   o_key_pulse      out  1-cycle strobe, accepted key (any code 0..15)
//   o_key_code[3:0]  out  code of last accepted key, held
//   o_cmd_pulse      out  1-cycle strobe, accepted key is 0xB/0xC/0xD
//   o_entry_bcd      out  entry buffer, newest digit in [3:0], unused digits 0
//   o_entry_len[3:0] out  digits currently held, 0..N_DIGITS
//   o_entry_valid    out  1-cycle strobe on '#' with a non-empty entry
//   o_entry_err      out  1-cycle strobe: digit when full, or '#' when empty
//
// FSM states
//   state      | meaning
//   S_IDLE     | no key seen, waiting for first scan event
//   S_DEBOUNCE | counting consecutive same-code events toward acceptance
//   S_HELD     | key accepted, waiting for REL_CNT event-free cycles
// ---------------------------------------------------------------------------
module keypad_entry_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DEB_CNT  = 3,
    parameter int REL_CNT  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cambio_digito,
    input  logic [4:0]            i_digito,
    output logic                  o_key_pulse,
    output logic [3:0]            o_key_code,
    output logic                  o_cmd_pulse,
    output logic [4*N_DIGITS-1:0] o_entry_bcd,
    output logic [3:0]            o_entry_len,
    output logic                  o_entry_valid,
    output logic                  o_entry_err
);

    localparam int BW = 4 * N_DIGITS;
    localparam int DW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam int GW = $clog2(REL_CNT);
    localparam logic [GW-1:0] GAP_TC = GW'(REL_CNT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_prev_tog;
    logic [3:0]      r_cand;
    logic [3:0]      w_cand_nxt;
    logic [DW-1:0]   r_deb;
    logic [DW-1:0]   w_deb_nxt;
    logic [GW-1:0]   r_gap;
    logic [GW-1:0]   w_gap_nxt;
    logic            w_ev;
    logic            w_accept;
    logic [3:0]      w_acc_code;

    logic            r_key_pulse;
    logic [3:0]      r_key_code;
    logic            r_cmd_pulse;
    logic [BW-1:0]   r_entry_bcd;
    logic [3:0]      r_entry_len;
    logic            r_entry_valid;
    logic            r_entry_err;
    logic            r_clr_pend;
    logic [BW-1:0]   w_cand_ext;

    // A toggle with no-key / invalid code is not an event.
    assign w_ev = (i_cambio_digito != r_prev_tog) && (i_digito < 5'd16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev_tog <= 1'b0;
            r_cand     <= 4'd0;
            r_deb      <= '0;
            r_gap      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_prev_tog <= i_cambio_digito;
            r_cand     <= w_cand_nxt;
            r_deb      <= w_deb_nxt;
            r_gap      <= w_gap_nxt;
        end
    end

    // The gap timer is a down-counter reloaded on each event; reaching zero
    // on an event-free cycle means REL_CNT quiet cycles have elapsed.
    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_deb_nxt   = r_deb;
        w_gap_nxt   = r_gap;
        w_accept    = 1'b0;
        w_acc_code  = r_cand;
        case (r_state)
            S_IDLE: begin
                if (w_ev) begin
                    w_cand_nxt = i_digito[3:0];
                    w_deb_nxt  = DW'(1);
                    w_gap_nxt  = GAP_TC;
                    if (DEB_CNT == 1) begin
                        w_accept    = 1'b1;
                        w_acc_code  = i_digito[3:0];
                        w_state_nxt = S_HELD;
                    end else begin
                        w_state_nxt = S_DEBOUNCE;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (w_ev) begin
                    w_gap_nxt = GAP_TC;
                    if (i_digito[3:0] == r_cand) begin
                        if (r_deb == DW'(DEB_CNT - 1)) begin
                            w_accept    = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_deb_nxt = r_deb + DW'(1);
                        end
                    end else begin
                        w_cand_nxt = i_digito[3:0];
                        w_deb_nxt  = DW'(1);
                    end
                end else if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            S_HELD: begin
                if (w_ev) begin
                    w_gap_nxt = GAP_TC;
                end else if (r_gap == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_gap_nxt = r_gap - GW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_cand_ext = BW'(w_acc_code);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_pulse   <= 1'b0;
            r_key_code    <= 4'd0;
            r_cmd_pulse   <= 1'b0;
            r_entry_bcd   <= '0;
            r_entry_len   <= 4'd0;
            r_entry_valid <= 1'b0;
            r_entry_err   <= 1'b0;
            r_clr_pend    <= 1'b0;
        end else begin
            r_key_pulse   <= 1'b0;
            r_cmd_pulse   <= 1'b0;
            r_entry_valid <= 1'b0;
            r_entry_err   <= 1'b0;
            // '#' presents the buffer for one cycle, then empties it.
            if (r_clr_pend) begin
                r_entry_bcd <= '0;
                r_entry_len <= 4'd0;
                r_clr_pend  <= 1'b0;
            end
            if (w_accept) begin
                r_key_pulse <= 1'b1;
                r_key_code  <= w_acc_code;
                if (w_acc_code <= 4'd9) begin
                    if (r_entry_len < 4'(N_DIGITS)) begin
                        r_entry_bcd <= (r_entry_bcd << 4) | w_cand_ext;
                        r_entry_len <= r_entry_len + 4'd1;
                    end else begin
                        r_entry_err <= 1'b1;
                    end
                end else begin
                    case (w_acc_code)
                        4'hA: begin
                            if (r_entry_len != 4'd0) begin
                                r_entry_bcd <= r_entry_bcd >> 4;
                                r_entry_len <= r_entry_len - 4'd1;
                            end
                        end
                        4'hF: begin
                            r_entry_bcd <= '0;
                            r_entry_len <= 4'd0;
                        end
                        4'hE: begin
                            if (r_entry_len != 4'd0) begin
                                r_entry_valid <= 1'b1;
                                r_clr_pend    <= 1'b1;
                            end else begin
                                r_entry_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_cmd_pulse <= 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    assign o_key_pulse   = r_key_pulse;
    assign o_key_code    = r_key_code;
    assign o_cmd_pulse   = r_cmd_pulse;
    assign o_entry_bcd   = r_entry_bcd;
    assign o_entry_len   = r_entry_len;
    assign o_entry_valid = r_entry_valid;
    assign o_entry_err   = r_entry_err;

endmodule
